ret_stack: RTL and testbench
============================

# ret_stack

Parametrised hardware return-address stack for the CPU's call/return and interrupt path, successor to the fixed 16×10 stack. On a call it stores the return address PC+1, and on interrupt entry it stores the interrupted PC unchanged. Each entry carries a tag bit, so the return path no longer needs an external interrupt-select to correct the popped value. Adds configurable width and depth, full/empty/count status, same-cycle push+pop (replace-top) and optional overflow/underflow detection.

## Interface
- AW, 10: address (PC) width in bits.
- DEPTH, 16: number of entries, ≥2, need not be a power of two.
- CW, $clog2(DEPTH+1): count width (derived, not overridden).

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- push  in  1  push request (call or interrupt entry).
- push_intr  in  1  qualifies push: 1 = interrupt entry, 0 = call.
- pop  in  1  pop request (return).
- pc_in  in  AW  current PC, sampled on push.
- top  out  AW  return address at top of stack, combinational from storage.
- top_intr  out  1  tag of top entry (1 = pushed by interrupt).
- count  out  CW  number of valid entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- err_ovf  out  1  sticky overflow flag.
- err_unf  out  1  sticky underflow flag.
- err_clr  in  1  synchronous clear of the sticky flags.

## Operation
- Entry value on push: push_intr ? pc_in : pc_in + 1, computed modulo 2^AW (so 0x3FF+1 = 0x000 at AW=10). The tag stores push_intr.
- The stack pointer equals count. The top entry is at index count−1.
- push only, not full: write the entry at index count, then count += 1.
- pop only, not empty: count −= 1. Storage is left untouched.
- push and pop together, not empty: overwrite the top entry in place. count is unchanged (replace-top).
- push and pop together, empty: treated as push only.
- push when full (no pop): request dropped, storage and count unchanged.
- pop when empty (no push): request ignored, count stays 0.
- When empty, top = 0 and top_intr = 0. Stale storage is never exposed.
- err_clr has priority under flag set: if err_clr and an error event occur in the same cycle, the flag ends up set.

## Timing
- Reset values: count = 0, empty = 1, full = 0, top = 0, top_intr = 0, err_ovf = 0, err_unf = 0. Storage contents are don't-care.
- Reset applied mid-operation takes effect immediately (asynchronous). A push or pop in that cycle is discarded.
- Latency: a push or pop sampled at edge N is reflected on top, count, empty and full after edge N, visible in cycle N+1.
- top and top_intr are combinational from the pointer and storage; there is no extra read-latency cycle.
- No handshake; every push and pop is single-cycle and always accepted or dropped per the rules above.

## Configuration
- RET_STACK_ERR_EN defined:
  - err_ovf sets on the first dropped push (push, no pop, full).
  - err_unf sets on an ignored pop (pop, no push, empty).
  - Both flags hold until err_clr or reset.
- RET_STACK_ERR_EN undefined:
  - err_ovf and err_unf are tied to 0 and err_clr is ignored.
  - Drop and ignore behaviour is otherwise identical.

## Structure
- Shared package cpu_pkg holds:
  - default constants PC_W = 10 and RSTACK_DEPTH = 16;
  - the entry typedef {intr tag, AW-bit address}.
- One sub-module, ret_stack_mem: a DEPTH × (AW+1) register array with one synchronous write port and one asynchronous read port.
- Pointer, status and error logic live in ret_stack.

## Test plan
- Reset, then push pc_in=0x010 (call) -> top=0x011, top_intr=0, count=1, empty=0. Pop -> count=0, empty=1, top=0.
- Interrupt push pc_in=0x020, then call push pc_in=0x100 -> top=0x101. Pop -> top=0x020, top_intr=1.
- Fill with 16 calls pc_in=k (k=0..15) -> full=1, top=0x010. A 17th push -> top unchanged and err_ovf=1 (with macro) or 0 (without). err_clr -> err_ovf=0.
- From count=3, push and pop in the same cycle with pc_in=0x3FF, call -> count=3, top=0x000 (wrap).
- Pop when empty -> count=0 and err_unf=1 (with macro). Assert reset mid-sequence with count=5 -> count=0 and all flags 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the default-width return-stack entry layout.
package cpu_pkg;

   localparam int PC_W         = 10;
   localparam int RSTACK_DEPTH = 16;

   // Tag sits above the address so a raw storage word reads as {intr, addr}
   typedef struct packed {
      logic              intr;
      logic [PC_W-1:0]   addr;
   } rs_entry_t;

endpackage

// File: rtl/ret_stack_if.sv
// Request/status bundle between the CPU sequencer (master) and the return-address stack (slave).
interface ret_stack_if
   import cpu_pkg::*;
#(
   parameter int AW    = PC_W,
   parameter int DEPTH = RSTACK_DEPTH
);

   localparam int CW = $clog2(DEPTH + 1);

   logic          push;
   logic          push_intr;
   logic          pop;
   logic [AW-1:0] pc_in;
   logic          err_clr;
   logic [AW-1:0] top;
   logic          top_intr;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          err_ovf;
   logic          err_unf;

   modport master (
      output push, push_intr, pop, pc_in, err_clr,
      input  top, top_intr, count, empty, full, err_ovf, err_unf
   );

   modport slave (
      input  push, push_intr, pop, pc_in, err_clr,
      output top, top_intr, count, empty, full, err_ovf, err_unf
   );

endinterface

// File: rtl/ret_stack_mem.sv
// DEPTH x (AW+1) register file: one synchronous write port, one asynchronous read port.
module ret_stack_mem
   import cpu_pkg::*;
#(
   parameter int AW    = PC_W,
   parameter int DEPTH = RSTACK_DEPTH,
   localparam int IW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [IW-1:0] i_waddr,
   input  logic [AW:0]   i_wdata,
   input  logic [IW-1:0] i_raddr,
   output logic [AW:0]   o_rdata
);

   logic [AW:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Non-power-of-two depths leave unused index codes; read those as zero
   assign o_rdata = (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/ret_stack.sv
// Return-address stack with tagged entries and replace-top; optional sticky
// overflow/underflow flags are built when RET_STACK_ERR_EN is defined.
module ret_stack
   import cpu_pkg::*;
#(
   parameter int AW    = PC_W,
   parameter int DEPTH = RSTACK_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   ret_stack_if.slave  bus
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   typedef struct packed {
      logic          intr;
      logic [AW-1:0] addr;
   } entry_t;

   logic [CW-1:0] r_count;
   logic          w_empty;
   logic          w_full;
   logic          w_replace;
   logic          w_pushOnly;
   logic          w_popOnly;
   logic          w_we;
   logic [IW-1:0] w_topIdx;
   logic [IW-1:0] w_wrIdx;
   logic [AW-1:0] w_retAddr;
   entry_t        w_wrEntry;
   entry_t        w_rdEntry;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CW'(DEPTH));

   // Push+pop on a non-empty stack rewrites the top; on an empty stack it is a plain push
   assign w_replace  = bus.push && bus.pop && !w_empty;
   assign w_pushOnly = bus.push && !w_replace && !w_full;
   assign w_popOnly  = bus.pop && !bus.push && !w_empty;
   assign w_we       = w_replace || w_pushOnly;

   assign w_topIdx   = IW'(r_count - CW'(1));
   assign w_wrIdx    = w_replace ? w_topIdx : IW'(r_count);

   // Calls return past the call instruction; interrupts resume the interrupted one
   assign w_retAddr  = bus.pc_in + AW'(1);
   assign w_wrEntry  = '{intr: bus.push_intr,
                         addr: bus.push_intr ? bus.pc_in : w_retAddr};

   ret_stack_mem #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_wrIdx),
      .i_wdata (w_wrEntry),
      .i_raddr (w_topIdx),
      .o_rdata (w_rdEntry)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_pushOnly) begin
         r_count <= r_count + CW'(1);
      end else if (w_popOnly) begin
         r_count <= r_count - CW'(1);
      end
   end

   // Popped entries stay in storage, so the top is masked whenever the stack is empty
   assign bus.top      = w_empty ? '0 : w_rdEntry.addr;
   assign bus.top_intr = w_empty ? 1'b0 : w_rdEntry.intr;
   assign bus.count    = r_count;
   assign bus.empty    = w_empty;
   assign bus.full     = w_full;

`ifdef RET_STACK_ERR_EN
   logic w_ovfEvt;
   logic w_unfEvt;
   logic r_errOvf;
   logic r_errUnf;

   assign w_ovfEvt = bus.push && !bus.pop && w_full;
   assign w_unfEvt = bus.pop && !bus.push && w_empty;

   // A new error event wins over a clear arriving in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_errOvf <= 1'b0;
         r_errUnf <= 1'b0;
      end else begin
         if (w_ovfEvt) begin
            r_errOvf <= 1'b1;
         end else if (bus.err_clr) begin
            r_errOvf <= 1'b0;
         end
         if (w_unfEvt) begin
            r_errUnf <= 1'b1;
         end else if (bus.err_clr) begin
            r_errUnf <= 1'b0;
         end
      end
   end

   assign bus.err_ovf = r_errOvf;
   assign bus.err_unf = r_errUnf;
`else
   assign bus.err_ovf = 1'b0;
   assign bus.err_unf = 1'b0;
`endif

endmodule

// File: tb/tb_ret_stack.sv
// Self-checking bench for ret_stack: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_ret_stack;
   import cpu_pkg::*;

   localparam int AW    = 10;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);
`ifdef RET_STACK_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   nVec = 0;
   int   nMis = 0;

   // Reference model: a queue of {intr, addr} entries, back = top of stack
   logic [AW:0] model[$];
   bit          mOvf;
   bit          mUnf;

   always #5 clk = ~clk;

   ret_stack_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

   ret_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic idleInputs();
      bus.push      = 1'b0;
      bus.push_intr = 1'b0;
      bus.pop       = 1'b0;
      bus.pc_in     = '0;
      bus.err_clr   = 1'b0;
   endtask

   task automatic applyStimulus(input bit p, input bit pi, input bit po,
                                input logic [AW-1:0] pc, input bit clr);
      bus.push      = p;
      bus.push_intr = pi;
      bus.pop       = po;
      bus.pc_in     = pc;
      bus.err_clr   = clr;
      @(posedge clk);
      #1;
      idleInputs();
   endtask

   task automatic doReset();
      reset = 1'b1;
      idleInputs();
      @(posedge clk);
      #1;
      reset = 1'b0;
      model.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
   endtask

   task automatic modelStep(input bit p, input bit pi, input bit po,
                            input logic [AW-1:0] pc, input bit clr);
      logic [AW-1:0] v;
      bit ovfE;
      bit unfE;
      v    = pi ? pc : pc + AW'(1);
      ovfE = 1'b0;
      unfE = 1'b0;
      if (p && po && model.size() > 0) begin
         model[model.size()-1] = {pi, v};
      end else if (p) begin
         if (model.size() < DEPTH) model.push_back({pi, v});
         else ovfE = 1'b1;
      end else if (po) begin
         if (model.size() > 0) void'(model.pop_back());
         else unfE = 1'b1;
      end
      if (ERR_EN) begin
         if (clr) begin
            mOvf = 1'b0;
            mUnf = 1'b0;
         end
         if (ovfE) mOvf = 1'b1;
         if (unfE) mUnf = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idleInputs();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      nVec++;
      if (bus.count !== CW'(0)) begin
         nMis++; $display("[TB] FAIL reset_count got %0d want 0", bus.count);
      end
      nVec++;
      if ({bus.empty, bus.full} !== 2'b10) begin
         nMis++; $display("[TB] FAIL reset_empty_full got %b%b want 10", bus.empty, bus.full);
      end
      nVec++;
      if ({bus.top_intr, bus.top} !== '0) begin
         nMis++; $display("[TB] FAIL reset_top got %b/%h want 0/000", bus.top_intr, bus.top);
      end
      nVec++;
      if ({bus.err_ovf, bus.err_unf} !== 2'b00) begin
         nMis++; $display("[TB] FAIL reset_flags got %b%b want 00", bus.err_ovf, bus.err_unf);
      end
   endtask

   task automatic test_call_pop();
      doReset();
      applyStimulus(1, 0, 0, 10'h010, 0);
      nVec++;
      if ({bus.top_intr, bus.top} !== {1'b0, 10'h011}) begin
         nMis++; $display("[TB] FAIL call_top got %b/%h want 0/011", bus.top_intr, bus.top);
      end
      nVec++;
      if ({bus.count, bus.empty} !== {CW'(1), 1'b0}) begin
         nMis++; $display("[TB] FAIL call_count got %0d/%b want 1/0", bus.count, bus.empty);
      end
      applyStimulus(0, 0, 1, 10'h000, 0);
      nVec++;
      if ({bus.count, bus.empty, bus.top} !== {CW'(0), 1'b1, 10'h000}) begin
         nMis++; $display("[TB] FAIL pop_empty got %0d/%b/%h want 0/1/000", bus.count, bus.empty, bus.top);
      end
   endtask

   task automatic test_intr_nest();
      doReset();
      applyStimulus(1, 1, 0, 10'h020, 0);
      nVec++;
      if ({bus.top_intr, bus.top} !== {1'b1, 10'h020}) begin
         nMis++; $display("[TB] FAIL intr_push_top got %b/%h want 1/020", bus.top_intr, bus.top);
      end
      applyStimulus(1, 0, 0, 10'h100, 0);
      nVec++;
      if ({bus.top_intr, bus.top, bus.count} !== {1'b0, 10'h101, CW'(2)}) begin
         nMis++; $display("[TB] FAIL nest_top got %b/%h/%0d want 0/101/2", bus.top_intr, bus.top, bus.count);
      end
      applyStimulus(0, 0, 1, 10'h000, 0);
      nVec++;
      if ({bus.top_intr, bus.top} !== {1'b1, 10'h020}) begin
         nMis++; $display("[TB] FAIL nest_pop_top got %b/%h want 1/020", bus.top_intr, bus.top);
      end
   endtask

   task automatic test_fill_overflow();
      doReset();
      for (int k = 0; k < DEPTH; k++) applyStimulus(1, 0, 0, AW'(k), 0);
      nVec++;
      if ({bus.full, bus.count, bus.top} !== {1'b1, CW'(16), 10'h010}) begin
         nMis++; $display("[TB] FAIL fill got full=%b cnt=%0d top=%h want 1/16/010", bus.full, bus.count, bus.top);
      end
      applyStimulus(1, 0, 0, 10'h200, 0);
      nVec++;
      if ({bus.top, bus.count} !== {10'h010, CW'(16)}) begin
         nMis++; $display("[TB] FAIL ovf_drop got top=%h cnt=%0d want 010/16", bus.top, bus.count);
      end
      nVec++;
      if (bus.err_ovf !== ERR_EN) begin
         nMis++; $display("[TB] FAIL ovf_flag got %b want %b", bus.err_ovf, ERR_EN);
      end
      applyStimulus(0, 0, 0, 10'h000, 1);
      nVec++;
      if (bus.err_ovf !== 1'b0) begin
         nMis++; $display("[TB] FAIL ovf_clear got %b want 0", bus.err_ovf);
      end
   endtask

   task automatic test_replace_wrap();
      doReset();
      for (int k = 1; k <= 3; k++) applyStimulus(1, 0, 0, AW'(k), 0);
      applyStimulus(1, 0, 1, 10'h3FF, 0);
      nVec++;
      if ({bus.count, bus.top_intr, bus.top} !== {CW'(3), 1'b0, 10'h000}) begin
         nMis++; $display("[TB] FAIL replace_wrap got %0d/%b/%h want 3/0/000", bus.count, bus.top_intr, bus.top);
      end
      applyStimulus(1, 1, 1, 10'h155, 0);
      nVec++;
      if ({bus.count, bus.top_intr, bus.top} !== {CW'(3), 1'b1, 10'h155}) begin
         nMis++; $display("[TB] FAIL replace_intr got %0d/%b/%h want 3/1/155", bus.count, bus.top_intr, bus.top);
      end
      applyStimulus(0, 0, 1, 10'h000, 0);
      nVec++;
      if ({bus.count, bus.top} !== {CW'(2), 10'h003}) begin
         nMis++; $display("[TB] FAIL replace_below got %0d/%h want 2/003", bus.count, bus.top);
      end
   endtask

   task automatic test_underflow_reset();
      doReset();
      applyStimulus(0, 0, 1, 10'h000, 0);
      nVec++;
      if ({bus.count, bus.err_unf, bus.err_ovf} !== {CW'(0), ERR_EN, 1'b0}) begin
         nMis++; $display("[TB] FAIL unf_flag got %0d/%b/%b want 0/%b/0", bus.count, bus.err_unf, bus.err_ovf, ERR_EN);
      end
      applyStimulus(0, 0, 1, 10'h000, 1);
      nVec++;
      if (bus.err_unf !== ERR_EN) begin
         nMis++; $display("[TB] FAIL unf_clr_priority got %b want %b", bus.err_unf, ERR_EN);
      end
      for (int k = 0; k < 5; k++) applyStimulus(1, k[0], 0, AW'(k * 7), 0);
      nVec++;
      if ({bus.count, bus.err_unf} !== {CW'(5), ERR_EN}) begin
         nMis++; $display("[TB] FAIL pre_reset got %0d/%b want 5/%b", bus.count, bus.err_unf, ERR_EN);
      end
      @(negedge clk);
      bus.push = 1'b1;
      bus.pc_in = 10'h2AA;
      reset = 1'b1;
      #1;
      nVec++;
      if ({bus.count, bus.empty, bus.top, bus.err_ovf, bus.err_unf} !== {CW'(0), 1'b1, 10'h000, 2'b00}) begin
         nMis++; $display("[TB] FAIL async_reset got %0d/%b/%h/%b%b want 0/1/000/00",
                          bus.count, bus.empty, bus.top, bus.err_ovf, bus.err_unf);
      end
      @(posedge clk);
      #1;
      nVec++;
      if (bus.count !== CW'(0)) begin
         nMis++; $display("[TB] FAIL reset_discard got %0d want 0", bus.count);
      end
      reset = 1'b0;
      idleInputs();
   endtask

   task automatic test_random();
      bit p, pi, po, clr;
      logic [AW-1:0] pc;
      logic [AW:0]   tv;
      logic [CW+AW+5:0] expV, gotV;
      doReset();
      for (int i = 0; i < 600; i++) begin
         p   = ($urandom_range(0, 99) < ((i < 300) ? 65 : 30));
         po  = ($urandom_range(0, 99) < ((i < 300) ? 30 : 65));
         pi  = $urandom_range(0, 1);
         pc  = AW'($urandom);
         clr = ($urandom_range(0, 15) == 0);
         applyStimulus(p, pi, po, pc, clr);
         modelStep(p, pi, po, pc, clr);
         tv   = (model.size() > 0) ? model[model.size()-1] : '0;
         expV = {CW'(model.size()), model.size() == 0, model.size() == DEPTH,
                 tv[AW-1:0], tv[AW], mOvf, mUnf};
         gotV = {bus.count, bus.empty, bus.full, bus.top, bus.top_intr, bus.err_ovf, bus.err_unf};
         nVec++;
         if (gotV !== expV) begin
            nMis++;
            $display("[TB] FAIL random_step %0d got %h want %h (count,empty,full,top,intr,ovf,unf)", i, gotV, expV);
         end
      end
   endtask

   initial begin
      test_reset();
      test_call_pop();
      test_intr_nest();
      test_fill_overflow();
      test_replace_wrap();
      test_underflow_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
